// File: rtl/trading_pkg.sv
// Types and defaults shared across the order/market-data paths of trading_system_top.
// The arbiter state encoding lives here so that status export can decode it.
package trading_pkg;

    localparam int SFP_DATA_W        = 64;
    localparam int MAX_BEATS_DEFAULT = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SEND  = 2'd1,
        DRAIN = 2'd2
    } arb_state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: the search starts one past the last grant.
// This block is shared with the market-data fan-in.
module rr_arbiter #(
    parameter int  NUM_REQ = 4,
    localparam int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   last_grant,
    output logic [IDX_W-1:0]   winner,
    output logic               any_valid
);

    always_comb begin : search
        int idx;
        // NOTE: every output gets a default before the search so no path leaves it unassigned (no latch).
        winner    = last_grant;
        any_valid = 1'b0;
        idx       = 0;
        for (int off = 1; off <= NUM_REQ; off++) begin
            idx = (int'(last_grant) + off) % NUM_REQ;
            if (!any_valid && req[IDX_W'(idx)]) begin
                any_valid = 1'b1;
                winner    = IDX_W'(idx);
            end
        end
    end

endmodule

// File: rtl/order_tx_arbiter.sv
// Packet-level round-robin arbiter sharing the SFP transmit stream between strategy engines.
// It locks the grant per message, truncates runaway messages and counts orders/aborts.
module order_tx_arbiter
    import trading_pkg::*;
#(
    parameter int  NUM_REQ   = 4,
    parameter int  DATA_W    = SFP_DATA_W,
    parameter int  MAX_BEATS = MAX_BEATS_DEFAULT,
    localparam int IDX_W     = $clog2(NUM_REQ)
) (
    input  logic                      clk_sys,
    input  logic                      rst,
    input  logic [NUM_REQ*DATA_W-1:0] req_data,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ-1:0]        req_last,
    output logic [NUM_REQ-1:0]        req_ready,
    input  logic [NUM_REQ-1:0]        req_enable,
    input  logic                      risk_halt,
    output logic [DATA_W-1:0]         sfp_tx_data,
    output logic                      sfp_tx_valid,
    output logic                      sfp_tx_last,
    input  logic                      sfp_tx_ready,
    output logic [IDX_W-1:0]          grant_id,
    output logic                      busy,
    output logic [31:0]               orders_sent,
    output logic [15:0]               abort_count
);

    localparam int CNT_W = $clog2(MAX_BEATS);

    arb_state_t         state, state_next;
    logic [IDX_W-1:0]   grant_next, arb_winner;
    logic               arb_any;
    logic [CNT_W-1:0]   beat_cnt, beat_cnt_next;
    logic [NUM_REQ-1:0] eligible;
    logic [DATA_W-1:0]  lane_data [NUM_REQ];
    logic               g_valid, g_last, at_max;
    logic               order_done, order_abort;

    for (genvar i = 0; i < NUM_REQ; i++) begin : g_lane
        assign lane_data[i] = req_data[i*DATA_W +: DATA_W];
    end

    // Halt and per-engine enables only matter where a new grant is chosen (IDLE).
    assign eligible = risk_halt ? '0 : (req_valid & req_enable);

    rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
        .req        (eligible),
        .last_grant (grant_id),
        .winner     (arb_winner),
        .any_valid  (arb_any)
    );

    assign g_valid = req_valid[grant_id];
    assign g_last  = req_last[grant_id];
    assign at_max  = (beat_cnt == CNT_W'(MAX_BEATS - 1));
    assign busy    = (state != IDLE);

    always_comb begin
        state_next    = state;
        grant_next    = grant_id;
        beat_cnt_next = beat_cnt;
        order_done    = 1'b0;
        order_abort   = 1'b0;
        req_ready     = '0;
        sfp_tx_data   = '0;
        sfp_tx_valid  = 1'b0;
        sfp_tx_last   = 1'b0;
        unique case (state)
            IDLE: begin
                if (arb_any) begin
                    grant_next    = arb_winner;
                    beat_cnt_next = '0;
                    state_next    = SEND;
                end
            end
            SEND: begin
                sfp_tx_data         = lane_data[grant_id];
                sfp_tx_valid        = g_valid;
                sfp_tx_last         = g_last | at_max;
                req_ready[grant_id] = sfp_tx_ready;
                if (g_valid && sfp_tx_ready) begin
                    beat_cnt_next = beat_cnt + CNT_W'(1);
                    if (g_last) begin
                        order_done = 1'b1;
                        state_next = IDLE;
                    end else if (at_max) begin
                        order_done  = 1'b1;
                        order_abort = 1'b1;
                        state_next  = DRAIN;
                    end
                end
            end
            DRAIN: begin
                // Swallow the tail of a truncated message without touching egress.
                req_ready[grant_id] = 1'b1;
                if (g_valid && g_last) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk_sys) begin
        if (rst) begin
            state       <= IDLE;
            grant_id    <= IDX_W'(NUM_REQ - 1);
            beat_cnt    <= '0;
            orders_sent <= '0;
            abort_count <= '0;
        end else begin
            state    <= state_next;
            grant_id <= grant_next;
            beat_cnt <= beat_cnt_next;
            if (order_done) begin
                orders_sent <= orders_sent + 32'd1;
            end
            if (order_abort && abort_count != 16'hFFFF) begin
                abort_count <= abort_count + 16'd1;
            end
        end
    end

endmodule

// File: doc/order_tx_arbiter.md
# order_tx_arbiter

Shares the single 64-bit SFP transmit stream between several order-generating strategy engines inside `trading_system_top`. It arbitrates whole order messages (multi-beat packets) round-robin, locks the grant until a packet's last beat is accepted, and gates new grants on a global risk halt. It also truncates runaway packets and keeps order and abort counters for status export.

## Interface
Parameters:
- `NUM_REQ`, 4: number of requesting engines (2..8).
- `DATA_W`, 64: beat width; matches `sfp_tx_data`.
- `MAX_BEATS`, 8: maximum beats per order message (2..255).

Ports. Clocking is decided: one clock, `clk_sys`; `rst` is a synchronous, active-high reset.
- `clk_sys`  in  1  system clock, 100 MHz.
- `rst`  in  1  synchronous reset, active high.
- `req_data`  in  `NUM_REQ*DATA_W`  beat from requester i in slice [i*DATA_W +: DATA_W].
- `req_valid`  in  `NUM_REQ`  per-requester beat valid.
- `req_last`  in  `NUM_REQ`  per-requester last beat of message.
- `req_ready`  out  `NUM_REQ`  per-requester beat accept.
- `req_enable`  in  `NUM_REQ`  per-requester arbitration enable (risk per engine).
- `risk_halt`  in  1  global halt: blocks new grants.
- `sfp_tx_data`  out  `DATA_W`  egress beat.
- `sfp_tx_valid`  out  1  egress valid.
- `sfp_tx_last`  out  1  egress last beat.
- `sfp_tx_ready`  in  1  egress accept.
- `grant_id`  out  `$clog2(NUM_REQ)`  current/most recent granted requester.
- `busy`  out  1  packet in flight (state ≠ IDLE).
- `orders_sent`  out  32  messages completed on egress.
- `abort_count`  out  16  messages truncated.

## Operation
- FSM states: IDLE, SEND, DRAIN.
- **IDLE**
  - Eligible set = `req_valid & req_enable`, forced to zero while `risk_halt` is high.
  - If the set is non-empty, register the round-robin winner into `grant_id`. Search starts at `grant_id+1` mod `NUM_REQ`.
  - Clear the beat counter and go to SEND.
  - All `req_ready` = 0; `sfp_tx_valid` = 0.
- **SEND** (combinational pass-through from requester g = `grant_id`)
  - `sfp_tx_data` = `req_data[g]`, `sfp_tx_valid` = `req_valid[g]`, `req_ready[g]` = `sfp_tx_ready`. Other `req_ready` bits = 0.
  - `sfp_tx_last` = `req_last[g]`, or forced to 1 when beat counter = `MAX_BEATS-1`.
  - A beat transfers when `sfp_tx_valid & sfp_tx_ready`; each transfer increments the beat counter.
  - Transfer with `req_last[g]` = 1: `orders_sent` += 1, go to IDLE.
  - Transfer with forced last and `req_last[g]` = 0: `orders_sent` += 1, `abort_count` += 1, go to DRAIN.
  - A gap in `req_valid[g]` mid-packet stalls the egress; the grant is held and no other requester is served.
- **DRAIN**
  - `req_ready[g]` = 1 and `sfp_tx_valid` = 0; the remaining requester beats are discarded.
  - On an accepted beat with `req_last[g]` = 1, go to IDLE.
- `risk_halt` and `req_enable` are sampled only in IDLE. An in-flight packet always completes; halt never truncates.
- Counters wrap: `orders_sent` at 2^32, `abort_count` saturates at 0xFFFF.

## Timing
- Reset values: state = IDLE, `grant_id` = `NUM_REQ-1` (so requester 0 wins first), `busy` = 0, all `req_ready` = 0, `sfp_tx_valid` = 0, `sfp_tx_last` = 0, `sfp_tx_data` = 0, counters = 0, beat counter = 0.
- Arbitration latency:
  - A request seen in IDLE on cycle N is granted at the edge ending N.
  - The first beat can transfer in cycle N+1.
- Data path latency is 0 cycles in SEND (combinational).
- There is one mandatory IDLE cycle between packets. Peak egress is therefore k beats per k+1 cycles.
- `rst` asserted mid-packet: the next edge returns to IDLE with reset values. The downstream sees a packet without last; the framer above handles this.
- Requester AXI-style rules: `req_data`/`req_last` are held stable while `req_valid` is high and not yet accepted. Egress obeys the same rule.

## Structure
- Package `trading_pkg`: `ARB_STATE_T` enum {IDLE, SEND, DRAIN}, `SFP_DATA_W` = 64, default `MAX_BEATS`.
- Sub-module `rr_arbiter`:
  - Parameter `NUM_REQ`.
  - Inputs: request vector, last grant index.
  - Outputs: winner index, any-valid.
  - Purely combinational; reused by the market-data fan-in.
- Top-level integration: `trading_system_top` instantiates this between the strategy engines and `sfp_tx_*`.

## Test plan
- **Single packet:** req0 sends 3 beats {0xA1, 0xA2, 0xA3 with last}, `sfp_tx_ready` = 1 → egress beats on cycles 1–3 after request, `sfp_tx_last` on 0xA3, `orders_sent` = 1, `grant_id` = 0.
- **Round-robin:** req0–req3 continuously valid with 2-beat packets → grant order 0,1,2,3,0; each packet is contiguous, with one IDLE cycle between packets.
- **Backpressure:** `sfp_tx_ready` toggles 1,0,1,0 during a 4-beat packet from req2 → no beat lost or duplicated, data held stable while stalled, grant held throughout.
- **Truncation:** `MAX_BEATS` = 8, req1 sends 11 beats with last on beat 11 → egress shows 8 beats with last on beat 8, beats 9–11 accepted and dropped, `abort_count` = 1, `orders_sent` = 1.
- **Risk gating:** `risk_halt` rises during beat 2 of req3's 4-beat packet → packet completes, then no grant while halted despite req0 valid. On release, req0 is granted the next cycle. With `req_enable[1]` = 0, req1 is never granted.
- **Reset mid-packet:** `rst` asserted during beat 2 → next cycle `sfp_tx_valid` = 0, `busy` = 0, counters = 0, `grant_id` = `NUM_REQ-1`.
